mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs (instruction, address, store data, rd address) and acts as the bus initiator towards the data memory.
- Returns load data, sign- or zero-extended, to the write-back path.
- Asserts a hold request to the pipeline controller while a bus access is outstanding.

Parameters:
- TIMEOUT, 16: bus-ack timeout in cycles counted in BUSY; counter width is clog2(TIMEOUT+1).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid_i  in  1  EX/MEM holds a load or store
- mem_we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  access size/sign, inst[14:12]
- mem_addr_i  in  ADDR_W  byte address
- mem_wdata_i  in  32  store data, right-aligned
- rd_addr_i  in  5  load destination register
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  word-aligned address, addr[1:0] forced 0
- bus_wem_o  out  4  byte write-enable mask
- bus_wdata_o  out  32  lane-placed store data
- bus_ack_i  in  1  bus completion
- bus_rdata_i  in  32  bus read word, valid with ack
- bus_err_i  in  1  bus error, valid with ack
- hold_req_o  out  1  stall request to ctrl
- ld_valid_o  out  1  one-cycle load-result pulse
- ld_rd_addr_o  out  5  destination for ld_data_o
- ld_data_o  out  32  extended load data
- err_o  out  1  one-cycle access-error pulse
- misalign_o  out  1  one-cycle misalignment pulse (optional feature only, else tied 0)

Behaviour:
- Reset: state=IDLE, timeout counter=0. All registered outputs are 0: bus_req_o, bus_we_o, bus_addr_o, bus_wem_o, bus_wdata_o, ld_valid_o, ld_rd_addr_o, ld_data_o, err_o, misalign_o. Reset asserted mid-access aborts immediately; bus_req_o drops asynchronously.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - req_valid_i=1 → capture size, sign, addr[1:0], rd_addr and we. Drive all bus_* registers. Go to BUSY; bus_req_o goes high the next cycle.
  - req_valid_i=0 → stay in IDLE.
- BUSY:
  - bus_req_o stays 1 and all bus_* outputs stay stable until the ack cycle.
  - bus_ack_i=1 → go to DONE and drop bus_req_o. Load: register extended data and rd_addr.
  - Counter increments each BUSY cycle without ack. When it reaches TIMEOUT, treat it as an ack with error.
- DONE: exactly one cycle.
  - Success: ld_valid_o=1 for loads only.
  - bus_err_i or timeout: err_o=1, ld_valid_o=0, ld_data_o=0.
  - req_valid_i is ignored in DONE, because it is still the same instruction. Go to IDLE.
- hold_req_o is combinational: (IDLE & req_valid_i) | BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum latency: request seen in cycle 0, bus_req_o high in cycle 1, ack in cycle 1 → DONE in cycle 2. Back-to-back accesses therefore take 3 cycles each.
- Size is funct3[1:0]: 00 byte, 01 half, 1x word. funct3[2]=1 selects zero-extend; word ignores it.
- Byte lanes and write data, by addr[1:0]:
  - byte: wem = 0001 << off, wdata = {4{wdata[7:0]}}.
  - half: wem = 0011 << (off[1]*2), wdata = {2{wdata[15:0]}}.
  - word: wem = 1111.
  - Loads: wem = 0000.
- Load extract: byte = rdata[8*off +: 8], half = rdata[16*off[1] +: 16]. Extend per the sign bit.
- An ack seen in IDLE or DONE is ignored.

Optional Feature:
- MEM_LSU_MISALIGN_TRAP_EN defined:
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - IDLE does not issue a bus request and goes straight to DONE.
  - In DONE, misalign_o=1 and err_o=1; no bus write occurs.
- Undefined:
  - Misaligned accesses are performed as if aligned. Half uses off[1], word ignores addr[1:0].
  - misalign_o is tied to 0.

Test Plan:
- LW addr 0x100, ack in 1st BUSY cycle with rdata 0xDEADBEEF, rd 5 → bus_addr 0x100, wem 0000; cycle 2 ld_valid=1, ld_data=0xDEADBEEF, ld_rd_addr=5; hold_req high in cycles 0–1 only.
- LB addr 0x203, rdata 0x80FF1234 → ld_data 0xFFFFFF80; same access as LBU → 0x00000080.
- SH addr 0x302, wdata 0x0000ABCD, ack delayed 3 cycles → wem 1100, wdata 0xABCDABCD; bus_* stable for all 4 BUSY cycles; ld_valid stays 0.
- No ack with TIMEOUT=16 → bus_req high for 16 cycles, then err_o pulse; hold released.
- Reset asserted while in BUSY → bus_req_o and hold_req_o go to 0 immediately; the next request after reset completes normally.
- MEM_LSU_MISALIGN_TRAP_EN defined, SW addr 0x401 → no bus_req; the next cycle has misalign_o=1 and err_o=1.

Source files
------------

// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu : memory-stage load/store unit, bus initiator towards data memory. |
// | Optional feature macro: MEM_LSU_MISALIGN_TRAP_EN (misaligned access trap). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              mem_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [4:0]        rd_addr_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_wem_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i,
  output logic              hold_req_o,
  output logic              ld_valid_o,
  output logic [4:0]        ld_rd_addr_o,
  output logic [31:0]       ld_data_o,
  output logic              err_o,
  output logic              misalign_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       size_q, off_q;
  logic             uns_q, we_q;
  logic [4:0]       rd_q;
  logic             misaligned, timeout_hit, complete, access_err;
  logic [3:0]       wem_new;
  logic [31:0]      wdata_new, byte_sh, half_sh, ld_ext;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign misaligned = (funct3_i[1:0] == 2'b01 && mem_addr_i[0]) ||
                      (funct3_i[1] && mem_addr_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The last counted cycle without ack is treated as an ack carrying an error.
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign complete    = (state == BUSY) && (bus_ack_i || timeout_hit);
  assign access_err  = bus_ack_i ? bus_err_i : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    hold_req_o = 1'b0;
    case (state)
      IDLE: if (req_valid_i) begin
        hold_req_o = 1'b1;
        state_next = misaligned ? DONE : BUSY;
      end
      BUSY: begin
        hold_req_o = 1'b1;
        if (complete) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wem_new   = 4'b0000;
    wdata_new = mem_wdata_i;
    if (mem_we_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          wem_new   = 4'b0001 << mem_addr_i[1:0];
          wdata_new = {4{mem_wdata_i[7:0]}};
        end
        2'b01: begin
          wem_new   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{mem_wdata_i[15:0]}};
        end
        default: wem_new = 4'b1111;
      endcase
    end
  end

  always_comb begin
    byte_sh = bus_rdata_i >> {off_q, 3'b000};
    half_sh = bus_rdata_i >> {off_q[1], 4'b0000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, byte_sh[7:0]}  : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   ld_ext = uns_q ? {16'b0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
      default: ld_ext = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt      <= '0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      rd_q         <= 5'd0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_wem_o    <= 4'b0000;
      bus_wdata_o  <= 32'd0;
      ld_valid_o   <= 1'b0;
      ld_rd_addr_o <= 5'd0;
      ld_data_o    <= 32'd0;
      err_o        <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          size_q  <= funct3_i[1:0];
          uns_q   <= funct3_i[2];
          off_q   <= mem_addr_i[1:0];
          rd_q    <= rd_addr_i;
          we_q    <= mem_we_i;
          tmo_cnt <= '0;
          if (misaligned) begin
            err_o      <= 1'b1;
            misalign_o <= 1'b1;
            ld_data_o  <= 32'd0;
          end else begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            bus_wem_o   <= wem_new;
            bus_wdata_o <= wdata_new;
          end
        end
        BUSY: begin
          if (complete) begin
            bus_req_o  <= 1'b0;
            err_o      <= access_err;
            ld_valid_o <= !we_q && !access_err;
            ld_data_o  <= (!we_q && !access_err) ? ld_ext : 32'd0;
            if (!we_q) ld_rd_addr_o <= rd_q;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          ld_valid_o <= 1'b0;
          err_o      <= 1'b0;
          misalign_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
